// File: rtl/ni_request_flit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ni_request_flit_sequencer
//  Brief    : Request-path packetizer. Accepts one descriptor at a time,
//             steers the downstream payload shifter via flit_counter /
//             is_payload, and emits header/body/tail flits onto the NoC
//             link under credit-based flow control.
//  Revision : 1.0 - initial release
// ============================================================================
module ni_request_flit_sequencer #(
    parameter int  FLIT_WIDTH        = 32,
    parameter int  FTYPEWD           = 2,
    parameter int  MAX_PAYLOAD_FLITS = 4,
    parameter int  COUNTER_WIDTH     = 3,
    parameter int  CREDITS           = 4,
    localparam int BASE_WIDTH        = FLIT_WIDTH - FTYPEWD
) (
    input  logic                     clock,
    input  logic                     reset,
    // Descriptor handshake
    input  logic                     req_valid,
    input  logic [BASE_WIDTH-1:0]    req_header,
    input  logic [COUNTER_WIDTH-1:0] req_len,
    output logic                     req_ack,
    output logic                     req_done,
    output logic                     busy,
    // Payload shifter interface
    output logic [COUNTER_WIDTH-1:0] flit_counter,
    output logic                     is_payload,
    input  logic [BASE_WIDTH-1:0]    payload_chunk,
    // NoC output link
    output logic [FLIT_WIDTH-1:0]    flit_out,
    output logic                     flit_valid,
    input  logic                     credit_in
);

    localparam int CREDIT_WIDTH = $clog2(CREDITS + 1);

    // Flit-type field encodings (MSBs of every flit)
    localparam logic [FTYPEWD-1:0] c_ftype_body   = FTYPEWD'(2'b00);
    localparam logic [FTYPEWD-1:0] c_ftype_head   = FTYPEWD'(2'b01);
    localparam logic [FTYPEWD-1:0] c_ftype_tail   = FTYPEWD'(2'b10);
    localparam logic [FTYPEWD-1:0] c_ftype_headtl = FTYPEWD'(2'b11);

    localparam logic [COUNTER_WIDTH-1:0] c_max_len      = COUNTER_WIDTH'(MAX_PAYLOAD_FLITS);
    localparam logic [COUNTER_WIDTH-1:0] c_cnt_one      = COUNTER_WIDTH'(1);
    localparam logic [CREDIT_WIDTH-1:0]  c_credits_full = CREDIT_WIDTH'(CREDITS);
    localparam logic [CREDIT_WIDTH-1:0]  c_credit_one   = CREDIT_WIDTH'(1);

    // Sequencer states
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_header  = 2'd1;
    localparam logic [1:0] c_st_payload = 2'd2;

    logic [1:0]               r_state;
    logic [BASE_WIDTH-1:0]    r_header;
    logic [COUNTER_WIDTH-1:0] r_len;
    logic [COUNTER_WIDTH-1:0] r_flit_counter;
    logic [FLIT_WIDTH-1:0]    r_flit_out;
    logic                     r_flit_valid;
    logic                     r_req_ack;
    logic                     r_req_done;
    logic                     r_busy;
    logic [CREDIT_WIDTH-1:0]  r_credit_count;

    logic                     w_credit_avail;
    logic                     w_send;
    logic                     w_last_payload;
    logic [COUNTER_WIDTH-1:0] w_last_idx;
    logic [COUNTER_WIDTH-1:0] w_len_clamped;

    // Oversized lengths are truncated so the shifter is never indexed past its end
    assign w_len_clamped  = (req_len > c_max_len) ? c_max_len : req_len;
    assign w_credit_avail = (r_credit_count != '0);
    // A flit leaves whenever a packet is in flight and the link has room
    assign w_send         = w_credit_avail &&
                            ((r_state == c_st_header) || (r_state == c_st_payload));
    // Only meaningful in PAYLOAD, where the latched length is at least 1
    assign w_last_idx     = r_len - c_cnt_one;
    assign w_last_payload = (r_flit_counter == w_last_idx);

    assign req_ack      = r_req_ack;
    assign req_done     = r_req_done;
    assign busy         = r_busy;
    assign flit_counter = r_flit_counter;
    assign flit_out     = r_flit_out;
    assign flit_valid   = r_flit_valid;
    // Decoded straight from state so the shifter sees it in the same cycle
    assign is_payload   = (r_state == c_st_payload);

    // Packet sequencing FSM with registered handshake and link outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_header       <= '0;
            r_len          <= '0;
            r_flit_counter <= '0;
            r_flit_out     <= '0;
            r_flit_valid   <= 1'b0;
            r_req_ack      <= 1'b0;
            r_req_done     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_req_ack    <= 1'b0;
            r_req_done   <= 1'b0;
            r_flit_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_header       <= req_header;
                        r_len          <= w_len_clamped;
                        r_flit_counter <= '0;
                        r_req_ack      <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= c_st_header;
                    end
                end
                c_st_header: begin
                    if (w_credit_avail) begin
                        r_flit_valid <= 1'b1;
                        if (r_len == '0) begin
                            // Zero-length packet: header doubles as tail
                            r_flit_out <= {c_ftype_headtl, r_header};
                            r_req_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= c_st_idle;
                        end else begin
                            r_flit_out <= {c_ftype_head, r_header};
                            r_state    <= c_st_payload;
                        end
                    end
                end
                c_st_payload: begin
                    if (w_credit_avail) begin
                        r_flit_valid <= 1'b1;
                        if (w_last_payload) begin
                            r_flit_out     <= {c_ftype_tail, payload_chunk};
                            r_req_done     <= 1'b1;
                            r_busy         <= 1'b0;
                            r_flit_counter <= '0;
                            r_state        <= c_st_idle;
                        end else begin
                            r_flit_out     <= {c_ftype_body, payload_chunk};
                            r_flit_counter <= r_flit_counter + c_cnt_one;
                        end
                    end
                end
                default: begin
                    r_state        <= c_st_idle;
                    r_busy         <= 1'b0;
                    r_flit_counter <= '0;
                end
            endcase
        end
    end

    // Downstream credit tracking: sends consume, credit_in returns, saturating at CREDITS
    always_ff @(posedge clock) begin
        if (reset) begin
            r_credit_count <= c_credits_full;
        end else if (w_send && !credit_in) begin
            r_credit_count <= r_credit_count - c_credit_one;
        end else if (!w_send && credit_in && (r_credit_count != c_credits_full)) begin
            r_credit_count <= r_credit_count + c_credit_one;
        end
    end

`ifndef SYNTHESIS
    // Credit counter never exceeds the downstream buffer depth
    a_credit_bound: assert property (@(posedge clock) disable iff (reset)
        r_credit_count <= c_credits_full);

    // Completion is always reported alongside a valid flit
    a_done_with_flit: assert property (@(posedge clock) disable iff (reset)
        r_req_done |-> r_flit_valid);

    // Payload state is never entered for a zero-length packet
    a_payload_len: assert property (@(posedge clock) disable iff (reset)
        (r_state == c_st_payload) |-> (r_len != '0));

    // The payload index stays inside the shifter range
    a_counter_range: assert property (@(posedge clock) disable iff (reset)
        r_flit_counter < c_max_len || r_flit_counter == '0);
`endif

endmodule
`default_nettype wire
